uart_tx_word: RTL and testbench

UART_TX_WORD -- requirements
Module: uart_tx_word

---
 rtl/uart_tx_word.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_word.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word.sv
// Word-wide UART transmitter: serialises WORD_CHARS characters back-to-back, least-significant first.
// Optional parity bit per character when UART_TX_PARITY_EN is defined.
module uart_tx_word #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned WORD_CHARS   = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                              Clock,
    input  logic                              rst,
    input  logic [DATA_BITS*WORD_CHARS-1:0]   in_data,
    input  logic                              in_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                              parity_odd,
`endif
    output logic                              in_ready,
    output logic                              TxD,
    output logic                              tx_busy,
    output logic                              char_done
);

    localparam int unsigned WORD_W = DATA_BITS * WORD_CHARS;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned CHAR_W = (WORD_CHARS > 1) ? $clog2(WORD_CHARS) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(WORD_CHARS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [BIT_W-1:0]    bit_idx, bit_d;
    logic [CHAR_W-1:0]   char_idx, char_d;
    logic                stop_idx, stop_d;
    logic [WORD_W-1:0]   shreg, sh_d;
    logic                txd_d;
    logic                char_done_d;
    logic                cnt_exp;
`ifdef UART_TX_PARITY_EN
    logic                par_odd_q, par_odd_d;
    logic                par_bit, par_bit_d;
`endif

    assign cnt_exp  = (cnt == '0);
    assign in_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    // State and datapath registers; reset parks the line high
    always_ff @(posedge Clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            char_idx  <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            TxD       <= 1'b1;
            char_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_odd_q <= 1'b0;
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_d;
            char_idx  <= char_d;
            stop_idx  <= stop_d;
            shreg     <= sh_d;
            TxD       <= txd_d;
            char_done <= char_done_d;
`ifdef UART_TX_PARITY_EN
            par_odd_q <= par_odd_d;
            par_bit   <= par_bit_d;
`endif
        end
    end

    // Next-state and next-output logic; TxD carries the value of the bit being entered
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        char_d  = char_idx;
        stop_d  = stop_idx;
        sh_d    = shreg;
        txd_d   = TxD;
`ifdef UART_TX_PARITY_EN
        par_odd_d = par_odd_q;
        par_bit_d = par_bit;
`endif
        if (state != IDLE) begin
            cnt_d = cnt_exp ? CNT_MAX : cnt - CNT_W'(1);
        end

        case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (in_valid) begin
                    state_d = START;
                    cnt_d   = CNT_MAX;
                    sh_d    = in_data;
                    char_d  = '0;
                    txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_odd_d = parity_odd;
`endif
                end
            end
            START: begin
                if (cnt_exp) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shreg[0];
`ifdef UART_TX_PARITY_EN
                    par_bit_d = (^shreg[DATA_BITS-1:0]) ^ par_odd_q;
`endif
                end
            end
            DATA: begin
                if (cnt_exp) begin
                    sh_d = shreg >> 1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_bit;
`else
                        state_d = STOP;
                        stop_d  = 1'b0;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_idx + BIT_W'(1);
                        txd_d = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_exp) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_exp) begin
                    if (stop_idx == LAST_STOP) begin
                        if (char_idx == LAST_CHAR) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            txd_d   = 1'b1;
                        end else begin
                            state_d = START;
                            char_d  = char_idx + CHAR_W'(1);
                            txd_d   = 1'b0;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Pulse lands on the final cycle of a character's last stop bit
        char_done_d = (state_d == STOP) && (stop_d == LAST_STOP) && (cnt_d == '0);
    end

endmodule

// File: tb/tb_uart_tx_word.sv
// Self-checking bench for uart_tx_word: random words decoded by a behavioural line receiver
// and compared against a scoreboard of accepted characters; a second instance checks STOP_BITS=2.
module tb_uart_tx_word;

    localparam int unsigned CPB = 4;
    localparam int unsigned DB  = 8;
    localparam int unsigned WC  = 4;
    localparam int unsigned SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int unsigned FRAME  = 1 + DB + P + SB;
    localparam int unsigned BUSY   = WC * FRAME * CPB;
    localparam int unsigned FRAME2 = 1 + DB + P + 2;

    logic              Clock = 1'b0;
    logic              rst;
    logic [DB*WC-1:0]  in_data;
    logic              in_valid;
    logic              parity_odd;
    logic              in_ready, TxD, tx_busy, char_done;

    logic [DB-1:0]     in_data2;
    logic              in_valid2;
    logic              in_ready2, TxD2, tx_busy2, char_done2;
`ifdef UART_TX_PARITY_EN
    logic              parity_odd2;
`endif

    always #5 Clock = ~Clock;

    uart_tx_word #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .WORD_CHARS(WC), .STOP_BITS(SB)) dut (
        .Clock     (Clock),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .in_ready  (in_ready),
        .TxD       (TxD),
        .tx_busy   (tx_busy),
        .char_done (char_done)
    );

    uart_tx_word #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .WORD_CHARS(1), .STOP_BITS(2)) dut2 (
        .Clock     (Clock),
        .rst       (rst),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd2),
`endif
        .in_ready  (in_ready2),
        .TxD       (TxD2),
        .tx_busy   (tx_busy2),
        .char_done (char_done2)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: event not seen, expected within cycle budget", name);
    endtask

    // Scoreboard of expected characters, filled at each accepted word
    logic [DB-1:0] exp_q[$];
    logic          exp_par_q[$];
    int            acc_cyc_q[$];
    int            cyc = 0;
    int            n_acc = 0;
    bit            start_chk = 0;

    always @(posedge Clock) begin
        cyc++;
        if (!rst && in_valid && in_ready) begin
            for (int i = 0; i < int'(WC); i++) begin
                exp_q.push_back(in_data[i*DB +: DB]);
                exp_par_q.push_back((^in_data[i*DB +: DB]) ^ parity_odd);
            end
            acc_cyc_q.push_back(cyc);
            n_acc++;
            start_chk = 1;
        end
    end

    // Monitor: behavioural receiver sampling mid-bit, plus busy-length and char_done tracking
    bit            rx_active = 0;
    int            rx_cyc = 0;
    logic [DB-1:0] rx_char;
    logic          rx_par;
    int            n_rx = 0;
    int            cd_count = 0;
    bit            cd_pending = 0;
    int            busy_len = 0;

    always @(negedge Clock) begin
        if (rst) begin
            rx_active  = 0;
            cd_pending = 0;
            start_chk  = 0;
            busy_len   = 0;
            exp_q.delete();
            exp_par_q.delete();
        end else begin
            if (start_chk) begin
                check("start_latency", TxD, 0);
                start_chk = 0;
            end
            if (char_done === 1'b1) cd_count++;
            if (cd_pending) begin
                check("char_done_align", char_done, 1);
                cd_pending = 0;
            end else if (char_done !== 1'b0) begin
                check("char_done_spurious", char_done, 0);
            end
            if (tx_busy) busy_len++;
            else if (busy_len != 0) begin
                check("busy_len", busy_len, BUSY);
                busy_len = 0;
            end
            if (!rx_active) begin
                if (TxD === 1'b0) begin
                    rx_active = 1;
                    rx_cyc    = 0;
                    rx_char   = '0;
                    rx_par    = 1'b0;
                end
            end else begin
                rx_cyc++;
                if (rx_cyc % CPB == CPB / 2) begin
                    int b;
                    b = rx_cyc / CPB;
                    if (b == 0) check("rx_start_bit", TxD, 0);
                    else if (b <= int'(DB)) rx_char[b-1] = TxD;
                    else if (P == 1 && b == int'(DB) + 1) rx_par = TxD;
                    else check("rx_stop_bit", TxD, 1);
                    if (b == int'(FRAME) - 1) begin
                        n_rx++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL rx_unexpected_char: got %0h, expected no character", rx_char);
                        end else begin
                            logic ep;
                            check("rx_char", rx_char, exp_q.pop_front());
                            ep = exp_par_q.pop_front();
`ifdef UART_TX_PARITY_EN
                            check("rx_parity", rx_par, ep);
`endif
                        end
                        cd_pending = 1;
                        rx_active  = 0;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [DB*WC-1:0] w, input logic po);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 2000) begin
            @(negedge Clock);
            k++;
        end
        if (k >= 2000) fail_timeout("send_ready");
        in_data    = w;
        parity_odd = po;
        in_valid   = 1'b1;
        @(negedge Clock);
        in_valid   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((tx_busy || rx_active || exp_q.size() != 0) && k < budget) begin
            @(negedge Clock);
            k++;
        end
        if (k >= budget) fail_timeout("wait_idle");
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    int   rx0, cd0, a0, lows, len, hi, pulses;
    bit   seq[$];
    logic tr[0:199];
    logic cdv[0:199];
    logic [3:0] v;
    logic [7:0] c2;

    initial begin
        in_data   = '0;
        in_valid  = 1'b0;
        parity_odd = 1'b0;
        in_data2  = '0;
        in_valid2 = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd2 = 1'b0;
`endif
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge Clock);
        check("reset_txd", TxD, 1);
        check("reset_in_ready", in_ready, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_char_done", char_done, 0);
        check("reset_txd2", TxD2, 1);
        rst = 1'b0;
        @(negedge Clock);

        // Fixed word, single pulse
        rx0 = n_rx; cd0 = cd_count;
        send_word(32'h44332211, 1'b0);
        wait_idle(400);
        check("word1_chars", n_rx - rx0, 4);
        check("word1_char_done", cd_count - cd0, 4);
        check("word1_in_ready", in_ready, 1);

        // Input changes after capture are ignored
        send_word(32'hA1B2C3D4, 1'(($urandom) % 2));
        repeat (49) @(negedge Clock);
        in_data = 32'hFFFFFFFF;
        wait_idle(400);

        // in_valid held high across two words
        a0 = n_acc;
        in_data  = 32'h5A0F3C96;
        in_valid = 1'b1;
        for (int k = 0; k < 10 && n_acc == a0; k++) @(negedge Clock);
        if (n_acc == a0) fail_timeout("held_accept1");
        in_data = 32'h87E1C3B4;
        for (int k = 0; k < 400 && n_acc == a0 + 1; k++) @(negedge Clock);
        in_valid = 1'b0;
        if (n_acc != a0 + 2) fail_timeout("held_accept2");
        wait_idle(400);
        check("held_accept_count", n_acc - a0, 2);
        check("held_word_spacing", acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-2], BUSY + 1);

        // Asynchronous reset mid-word
        send_word($urandom, 1'b0);
        repeat (49) @(negedge Clock);
        #2 rst = 1'b1;
        #1;
        check("midreset_txd", TxD, 1);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_tx_busy", tx_busy, 0);
        check("midreset_char_done", char_done, 0);
        repeat (2) @(negedge Clock);
        rst = 1'b0;
        lows = 0;
        repeat (100) begin
            @(negedge Clock);
            if (TxD !== 1'b1) lows++;
        end
        check("post_reset_no_low", lows, 0);

        // First edge with in_valid after reset accepts
        a0 = n_acc;
        in_data  = $urandom;
        in_valid = 1'b1;
        @(posedge Clock);
        #1 check("accept_first_edge", n_acc - a0, 1);
        @(negedge Clock);
        in_valid = 1'b0;
        wait_idle(400);

        // Random words with in_valid noise while busy
        for (int w = 0; w < 8; w++) begin
            send_word($urandom, 1'(($urandom) % 2));
            for (int k = 0; k < 60; k++) begin
                @(negedge Clock);
                in_valid = 1'(($urandom) % 2);
                in_data  = $urandom;
            end
            in_valid = 1'b0;
            wait_idle(800);
            repeat ($urandom_range(0, 3)) @(negedge Clock);
        end

`ifdef UART_TX_PARITY_EN
        send_word(32'h00000007, 1'b0);
        wait_idle(400);
`endif

        // Two stop bits, single character A5
        c2 = 8'hA5;
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(c2[i]);
`ifdef UART_TX_PARITY_EN
        seq.push_back(^c2);
`endif
        seq.push_back(1'b1);
        seq.push_back(1'b1);
        check("d2_ready", in_ready2, 1);
        in_data2  = c2;
        in_valid2 = 1'b1;
        @(negedge Clock);
        in_valid2 = 1'b0;
        len = 0;
        while (tx_busy2 && len < 200) begin
            tr[len]  = TxD2;
            cdv[len] = char_done2;
            len++;
            @(negedge Clock);
        end
        check("d2_busy_len", len, FRAME2 * CPB);
        for (int j = 0; j < seq.size(); j++) begin
            for (int k = 0; k < int'(CPB); k++) v[k] = tr[j*CPB + k];
            check("d2_bit", v, {4{seq[j]}});
        end
        hi = 0;
        pulses = 0;
        for (int k = (FRAME2 - 2) * CPB; k < len; k++) if (tr[k] === 1'b1) hi++;
        for (int k = 0; k < len; k++) if (cdv[k] === 1'b1) pulses++;
        check("d2_stop_high", hi, 2 * CPB);
        check("d2_char_done_count", pulses, 1);
        check("d2_char_done_last", cdv[(len > 0) ? len - 1 : 0], 1);
        check("d2_idle_txd", TxD2, 1);

        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
